img2col_ifm_gen: RTL and testbench
==================================

Name: img2col_ifm_gen

Overview:
Parametrised successor to the fixed img2col IFM unit. It walks one 2D feature-map tile stored row-major in the IFM BRAM, with one DATA_W word per pixel holding all channels. It emits im2col patch elements to the cube input buffer and adds stride (1/2), zero padding (0..PAD_MAX), a configurable output start position with row wrap, and a configurable BRAM read latency. It sits between the IFM BRAM read port and the cube-unit input buffer, and is started by the tile controller.

Parameters:
DATA_W, 128, pixel word width (channels × 8 bit)
RD_ADDR_W, 10, IFM BRAM address width
WR_ADDR_W, 5, output buffer row address (kernel-offset index); must satisfy 2^WR_ADDR_W ≥ KMAX²
LANE_W, 4, output position index width; valid_num max 2^LANE_W−1
DIM_W, 6, tile dimension / coordinate width
KMAX, 5, largest supported ksize
PAD_MAX, 2, largest padding
RD_LAT, 1, BRAM read latency in cycles (≥1)

Ports:
clock  in  1  system clock
rst  in  1  asynchronous, active-high reset
i2c_ifm_start  in  1  start request, sampled only when i2c_ready=1 and addr_valid=1
ksize  in  4  kernel size 1..KMAX
stride  in  2  1 or 2
pad  in  2  zero padding 0..PAD_MAX
tile_length  in  DIM_W  input tile width
tile_height  in  DIM_W  input tile height
start_row  in  DIM_W  output row of first position
start_col  in  DIM_W  output column of first position
valid_num  in  LANE_W  number of output positions
addr_valid  in  1  base_addr qualifier
base_addr  in  RD_ADDR_W  BRAM address of tile pixel (0,0)
pixels_in  in  DATA_W  BRAM read data
i2c_ready  out  1  idle, accepting start
i2c_done  out  1  one-cycle pulse after the last write
ifm_rd_en  out  1  BRAM read enable
ifm_rd_addr  out  RD_ADDR_W  BRAM read address
ifm_wr_en  out  1  output write strobe
ifm_wr_addr  out  WR_ADDR_W  kernel offset index k = kr*ksize+kc
ifm_wr_lane  out  LANE_W  position index j
pixels_out  out  DATA_W  pixel word, or zero for padded/out-of-map elements

Behaviour:
- Reset (async, rst=1): state IDLE, i2c_ready=1, every other output 0, latency pipeline flushed. Holds mid-operation; no partial writes after release.
- Derived sizes: OW=((tile_length+2*pad−ksize)>>(stride−1))+1; OH is the same formula with tile_height. Computed in CALC, registered.
- FSM:
  - IDLE: i2c_ready=1. Start with addr_valid=1 → latch all config → CALC. Start with addr_valid=0 is ignored.
  - CALC: 1 cycle. valid_num=0 → DONE directly, no reads or writes. Otherwise → RUN.
  - RUN: one element issued per cycle. Outer loop k over 0..ksize²−1 (kr,kc row-major). Inner loop j over 0..valid_num−1.
    - Position j: (oy,ox) = (start_row,start_col) advanced j steps; ox wraps at OW to 0 with oy+1.
    - iy=oy*stride+kr−pad, ix=ox*stride+kc−pad, using signed arithmetic with DIM_W+2 bits.
    - In-bounds (0≤iy<tile_height, 0≤ix<tile_length, oy<OH): ifm_rd_en=1, ifm_rd_addr=base_addr+iy*tile_length+ix, taken modulo 2^RD_ADDR_W.
    - Otherwise: ifm_rd_en=0 and a zero element is marked.
    - Last element issued → DRAIN.
  - DRAIN: RD_LAT cycles → DONE.
  - DONE: i2c_done=1 for 1 cycle → IDLE.
- Write path: {issue, k, j, zero} is delayed RD_LAT cycles. Then ifm_wr_en=1, ifm_wr_addr=k, ifm_wr_lane=j, pixels_out = zero ? 0 : pixels_in. Every issued element yields exactly one write, in issue order.
- Start while busy: ignored. Config input changes after CALC: no effect.
- Total latency from accepted start to i2c_done: 1 + ksize²·valid_num + RD_LAT + 1 cycles.

Decomposition:
- Shared package: FSM state enum (IDLE, CALC, RUN, DRAIN, DONE), default widths, KMAX/PAD_MAX constants.
- One sub-module, i2c_coord_gen: the k/j/oy/ox counters and bounds check, producing {rd_en, rd_addr, k, j, zero, last}.
- Top level: FSM plus the RD_LAT delay line.

Test Plan:
- BRAM word i = i; tile 28×28, base_addr=16, ksize=3, stride=1, pad=0, start (0,0), valid_num=8 → 72 writes. k=0 lane j = 16+j; k=4 lane 0 = 45; k=8 lane 7 = 16+56+2+7=81. Single i2c_done pulse 1+72+1+1=75 cycles after the accepted start.
- Same config with pad=1 → k=0 lane 0 is a zero write with no rd_en in its issue cycle; k=4 lane 0 = 16.
- stride=2, pad=0, valid_num=4 → k=0 lanes = 16, 18, 20, 22.
- start_col=24, stride=1, pad=0, valid_num=4 (OW=26) → k=0 lanes = 40, 41, 44, 45 (wrap to row 1).
- rst pulsed during RUN → all outputs 0 immediately, i2c_ready=1. A new start then completes with a correct 72-write sequence. valid_num=0 → i2c_done with no writes.
- addr_valid=0 with start → ignored, i2c_ready stays 1. Start held high during RUN → exactly one operation runs.

Source files
------------

// File: rtl/img2col_ifm_gen_pkg.sv
// Shared constants and FSM state encodings for the img2col IFM generator.
package img2col_ifm_gen_pkg;

  localparam int KMAX    = 5;
  localparam int PAD_MAX = 2;
  localparam int KS_W    = 4;
  localparam int ST_W    = 3;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_CALC  = 3'd1;
  localparam logic [ST_W-1:0] S_RUN   = 3'd2;
  localparam logic [ST_W-1:0] S_DRAIN = 3'd3;
  localparam logic [ST_W-1:0] S_DONE  = 3'd4;

endpackage

// File: rtl/img2col_ifm_gen_coord_gen.sv
// Kernel-offset / output-position walker with bounds check and BRAM address generation.
module i2c_coord_gen
  import img2col_ifm_gen_pkg::*;
#(
  parameter int RD_ADDR_W = 10,
  parameter int WR_ADDR_W = 5,
  parameter int LANE_W    = 4,
  parameter int DIM_W     = 6
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [KS_W-1:0]      ksize,
  input  logic [1:0]           stride,
  input  logic [1:0]           pad,
  input  logic [DIM_W-1:0]     tile_length,
  input  logic [DIM_W-1:0]     tile_height,
  input  logic [DIM_W-1:0]     start_row,
  input  logic [DIM_W-1:0]     start_col,
  input  logic [LANE_W-1:0]    valid_num,
  input  logic [RD_ADDR_W-1:0] base_addr,
  input  logic [DIM_W+1:0]     ow,
  input  logic [DIM_W+1:0]     oh,
  output logic                 rd_en,
  output logic [RD_ADDR_W-1:0] rd_addr,
  output logic [WR_ADDR_W-1:0] k,
  output logic [LANE_W-1:0]    j,
  output logic                 zero,
  output logic                 last
);

  localparam int CW = DIM_W + 2;

  logic [KS_W-1:0]  kr, kc;
  logic [DIM_W-1:0] oy, ox;
  logic             j_wrap, kc_wrap, in_bounds;
  logic [CW-1:0]    ys, xs, iy, ix;

  assign j_wrap  = (j == valid_num - 1'b1);
  assign kc_wrap = (kc == ksize - 4'd1);
  assign last    = j_wrap && kc_wrap && (kr == ksize - 4'd1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      kr <= '0;
      kc <= '0;
      k  <= '0;
      j  <= '0;
      oy <= '0;
      ox <= '0;
    end else if (load) begin
      kr <= '0;
      kc <= '0;
      k  <= '0;
      j  <= '0;
      oy <= start_row;
      ox <= start_col;
    end else if (advance) begin
      if (j_wrap) begin
        j  <= '0;
        oy <= start_row;
        ox <= start_col;
        k  <= k + 1'b1;
        if (kc_wrap) begin
          kc <= '0;
          kr <= kr + 1'b1;
        end else begin
          kc <= kc + 1'b1;
        end
      end else begin
        j <= j + 1'b1;
        // Output positions run row-major across the output map width.
        if (CW'(ox) + CW'(1) >= ow) begin
          ox <= '0;
          oy <= oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end

  // Signed input coordinates; the top bit flags a negative (padding) position.
  assign ys = (stride == 2'd2) ? {1'b0, oy, 1'b0} : {2'b00, oy};
  assign xs = (stride == 2'd2) ? {1'b0, ox, 1'b0} : {2'b00, ox};
  assign iy = ys + CW'(kr) - CW'(pad);
  assign ix = xs + CW'(kc) - CW'(pad);

  assign in_bounds = !iy[CW-1] && !ix[CW-1] &&
                     (iy < CW'(tile_height)) && (ix < CW'(tile_length)) &&
                     (CW'(oy) < oh);

  assign rd_en   = advance && in_bounds;
  assign zero    = !in_bounds;
  assign rd_addr = rd_en ? base_addr
                           + RD_ADDR_W'(iy[DIM_W-1:0]) * RD_ADDR_W'(tile_length)
                           + RD_ADDR_W'(ix[DIM_W-1:0])
                         : '0;

endmodule

// File: rtl/img2col_ifm_gen.sv
// im2col IFM generator: sequencing FSM plus the BRAM read-latency delay line.
// state | meaning
// IDLE  | ready, waiting for start with a valid base address
// CALC  | derive output map size from latched config
// RUN   | issue one patch element per cycle
// DRAIN | wait out BRAM read latency
// DONE  | one-cycle completion pulse
module img2col_ifm_gen
  import img2col_ifm_gen_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int RD_ADDR_W = 10,
  parameter int WR_ADDR_W = 5,
  parameter int LANE_W    = 4,
  parameter int DIM_W     = 6,
  parameter int RD_LAT    = 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 i2c_ifm_start,
  input  logic [KS_W-1:0]      ksize,
  input  logic [1:0]           stride,
  input  logic [1:0]           pad,
  input  logic [DIM_W-1:0]     tile_length,
  input  logic [DIM_W-1:0]     tile_height,
  input  logic [DIM_W-1:0]     start_row,
  input  logic [DIM_W-1:0]     start_col,
  input  logic [LANE_W-1:0]    valid_num,
  input  logic                 addr_valid,
  input  logic [RD_ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0]    pixels_in,
  output logic                 i2c_ready,
  output logic                 i2c_done,
  output logic                 ifm_rd_en,
  output logic [RD_ADDR_W-1:0] ifm_rd_addr,
  output logic                 ifm_wr_en,
  output logic [WR_ADDR_W-1:0] ifm_wr_addr,
  output logic [LANE_W-1:0]    ifm_wr_lane,
  output logic [DATA_W-1:0]    pixels_out
);

  localparam int CW  = DIM_W + 2;
  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [ST_W-1:0]      state;
  logic [DCW-1:0]       drain_cnt;
  logic [KS_W-1:0]      ksize_q;
  logic [1:0]           stride_q, pad_q;
  logic [DIM_W-1:0]     tl_q, th_q, sr_q, sc_q;
  logic [LANE_W-1:0]    vn_q;
  logic [RD_ADDR_W-1:0] base_q;
  logic [CW-1:0]        ow_q, oh_q, span_w, span_h, ow_c, oh_c;
  logic                 accept;

  logic                 cg_last, cg_zero;
  logic [WR_ADDR_W-1:0] cg_k;
  logic [LANE_W-1:0]    cg_j;

  assign accept = (state == S_IDLE) && i2c_ifm_start && addr_valid;

  assign span_w = CW'(tl_q) + CW'({pad_q, 1'b0}) - CW'(ksize_q);
  assign span_h = CW'(th_q) + CW'({pad_q, 1'b0}) - CW'(ksize_q);
  assign ow_c   = ((stride_q == 2'd2) ? (span_w >> 1) : span_w) + CW'(1);
  assign oh_c   = ((stride_q == 2'd2) ? (span_h >> 1) : span_h) + CW'(1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      ksize_q   <= '0;
      stride_q  <= '0;
      pad_q     <= '0;
      tl_q      <= '0;
      th_q      <= '0;
      sr_q      <= '0;
      sc_q      <= '0;
      vn_q      <= '0;
      base_q    <= '0;
      ow_q      <= '0;
      oh_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          ksize_q  <= ksize;
          stride_q <= stride;
          pad_q    <= pad;
          tl_q     <= tile_length;
          th_q     <= tile_height;
          sr_q     <= start_row;
          sc_q     <= start_col;
          vn_q     <= valid_num;
          base_q   <= base_addr;
          state    <= S_CALC;
        end
        S_CALC: begin
          ow_q  <= ow_c;
          oh_q  <= oh_c;
          state <= (vn_q == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (cg_last) begin
          drain_cnt <= DCW'(RD_LAT - 1);
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_DONE;
          else drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign i2c_ready = (state == S_IDLE);
  assign i2c_done  = (state == S_DONE);

  i2c_coord_gen #(
    .RD_ADDR_W (RD_ADDR_W),
    .WR_ADDR_W (WR_ADDR_W),
    .LANE_W    (LANE_W),
    .DIM_W     (DIM_W)
  ) u_coord (
    .clock       (clock),
    .rst         (rst),
    .load        (state == S_CALC),
    .advance     (state == S_RUN),
    .ksize       (ksize_q),
    .stride      (stride_q),
    .pad         (pad_q),
    .tile_length (tl_q),
    .tile_height (th_q),
    .start_row   (sr_q),
    .start_col   (sc_q),
    .valid_num   (vn_q),
    .base_addr   (base_q),
    .ow          (ow_q),
    .oh          (oh_q),
    .rd_en       (ifm_rd_en),
    .rd_addr     (ifm_rd_addr),
    .k           (cg_k),
    .j           (cg_j),
    .zero        (cg_zero),
    .last        (cg_last)
  );

  // Element tags travel alongside the BRAM read so data and position line up.
  logic [RD_LAT-1:0]    dl_vld, dl_zero;
  logic [WR_ADDR_W-1:0] dl_k [RD_LAT];
  logic [LANE_W-1:0]    dl_j [RD_LAT];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dl_vld  <= '0;
      dl_zero <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_k[i] <= '0;
        dl_j[i] <= '0;
      end
    end else begin
      dl_vld[0]  <= (state == S_RUN);
      dl_zero[0] <= cg_zero;
      dl_k[0]    <= cg_k;
      dl_j[0]    <= cg_j;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_zero[i] <= dl_zero[i-1];
        dl_k[i]    <= dl_k[i-1];
        dl_j[i]    <= dl_j[i-1];
      end
    end
  end

  assign ifm_wr_en   = dl_vld[RD_LAT-1];
  assign ifm_wr_addr = ifm_wr_en ? dl_k[RD_LAT-1] : '0;
  assign ifm_wr_lane = ifm_wr_en ? dl_j[RD_LAT-1] : '0;
  assign pixels_out  = (ifm_wr_en && !dl_zero[RD_LAT-1]) ? pixels_in : '0;

endmodule

// File: tb/tb_img2col_ifm_gen.sv
// Directed bench for img2col_ifm_gen: BRAM word i holds value i, 28x28 tile at base 16.
module tb_img2col_ifm_gen;

  localparam int DATA_W    = 128;
  localparam int RD_ADDR_W = 10;
  localparam int WR_ADDR_W = 5;
  localparam int LANE_W    = 4;
  localparam int DIM_W     = 6;
  localparam int RD_LAT    = 1;

  logic                 clock = 1'b0;
  logic                 rst;
  logic                 i2c_ifm_start;
  logic [3:0]           ksize;
  logic [1:0]           stride, pad;
  logic [DIM_W-1:0]     tile_length, tile_height, start_row, start_col;
  logic [LANE_W-1:0]    valid_num;
  logic                 addr_valid;
  logic [RD_ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0]    pixels_in;
  logic                 i2c_ready, i2c_done, ifm_rd_en, ifm_wr_en;
  logic [RD_ADDR_W-1:0] ifm_rd_addr;
  logic [WR_ADDR_W-1:0] ifm_wr_addr;
  logic [LANE_W-1:0]    ifm_wr_lane;
  logic [DATA_W-1:0]    pixels_out;

  always #5 clock = ~clock;

  img2col_ifm_gen #(
    .DATA_W(DATA_W), .RD_ADDR_W(RD_ADDR_W), .WR_ADDR_W(WR_ADDR_W),
    .LANE_W(LANE_W), .DIM_W(DIM_W), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .rst(rst), .i2c_ifm_start(i2c_ifm_start),
    .ksize(ksize), .stride(stride), .pad(pad),
    .tile_length(tile_length), .tile_height(tile_height),
    .start_row(start_row), .start_col(start_col), .valid_num(valid_num),
    .addr_valid(addr_valid), .base_addr(base_addr), .pixels_in(pixels_in),
    .i2c_ready(i2c_ready), .i2c_done(i2c_done),
    .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
    .ifm_wr_en(ifm_wr_en), .ifm_wr_addr(ifm_wr_addr),
    .ifm_wr_lane(ifm_wr_lane), .pixels_out(pixels_out)
  );

  // One-cycle-latency BRAM whose word i contains i.
  always @(posedge clock)
    if (ifm_rd_en) pixels_in <= DATA_W'(ifm_rd_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] wr_data [0:31][0:15];
  int   wr_cnt, done_cnt, done_cyc, ord_err;
  logic rd_first;

  task automatic set_cfg(input int ks, input int st, input int pd, input int sr,
                         input int sc, input int vn);
    ksize       = 4'(ks);
    stride      = 2'(st);
    pad         = 2'(pd);
    tile_length = 6'd28;
    tile_height = 6'd28;
    start_row   = 6'(sr);
    start_col   = 6'(sc);
    valid_num   = 4'(vn);
    base_addr   = 10'd16;
    addr_valid  = 1'b1;
  endtask

  // Starts one operation and records every write, done pulse and first-issue read enable.
  task automatic run_op(input int ks, input int st, input int pd, input int sr,
                        input int sc, input int vn, input bit hold);
    int budget, ek, ej;
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 16; b++) wr_data[a][b] = '1;
    wr_cnt = 0; done_cnt = 0; done_cyc = 0; ord_err = 0; rd_first = 1'bx;
    ek = 0; ej = 0;
    budget = 2 + ks * ks * vn + RD_LAT + 8;
    @(negedge clock);
    set_cfg(ks, st, pd, sr, sc, vn);
    i2c_ifm_start = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clock);
      if (!hold) i2c_ifm_start = 1'b0;
      if (n == 2) rd_first = ifm_rd_en;
      if (n == 3) begin
        ksize = 4'd1; stride = 2'd2; pad = 2'd0; base_addr = '0;
        valid_num = 4'd15; start_col = 6'd3; tile_length = 6'd5;
      end
      if (ifm_wr_en) begin
        wr_cnt++;
        if (int'(ifm_wr_addr) != ek || int'(ifm_wr_lane) != ej) ord_err++;
        wr_data[ifm_wr_addr][ifm_wr_lane] = pixels_out;
        if (ej == vn - 1) begin ej = 0; ek++; end
        else ej++;
      end
      if (i2c_done) begin
        done_cnt++;
        done_cyc = n;
        i2c_ifm_start = 1'b0;
      end
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    i2c_ifm_start = 1'b0;
    set_cfg(3, 1, 0, 0, 0, 8);
    repeat (2) @(negedge clock);
    chk("rst_ready", i2c_ready, 1);
    chk("rst_done", i2c_done, 0);
    chk("rst_rd_en", ifm_rd_en, 0);
    chk("rst_rd_addr", ifm_rd_addr, 0);
    chk("rst_wr_en", ifm_wr_en, 0);
    chk("rst_pix", pixels_out, 0);
    rst = 1'b0;

    // Basic 3x3, stride 1, no padding, 8 positions.
    run_op(3, 1, 0, 0, 0, 8, 1'b0);
    chk("t1_wr_cnt", wr_cnt, 72);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, 75);
    chk("t1_order", ord_err, 0);
    chk("t1_rd_first", rd_first, 1);
    for (int j = 0; j < 8; j++) chk($sformatf("t1_k0_l%0d", j), wr_data[0][j], 16 + j);
    chk("t1_k4_l0", wr_data[4][0], 45);
    chk("t1_k8_l7", wr_data[8][7], 81);

    // Padding 1: first element is padding.
    run_op(3, 1, 1, 0, 0, 8, 1'b0);
    chk("t2_k0_l0", wr_data[0][0], 0);
    chk("t2_rd_first", rd_first, 0);
    chk("t2_k4_l0", wr_data[4][0], 16);
    chk("t2_k4_l1", wr_data[4][1], 17);
    chk("t2_wr_cnt", wr_cnt, 72);

    // Stride 2.
    run_op(3, 2, 0, 0, 0, 4, 1'b0);
    chk("t3_wr_cnt", wr_cnt, 36);
    for (int j = 0; j < 4; j++) chk($sformatf("t3_k0_l%0d", j), wr_data[0][j], 16 + 2 * j);

    // Row wrap at OW=26 from start column 24.
    run_op(3, 1, 0, 0, 24, 4, 1'b0);
    chk("t4_k0_l0", wr_data[0][0], 40);
    chk("t4_k0_l1", wr_data[0][1], 41);
    chk("t4_k0_l2", wr_data[0][2], 44);
    chk("t4_k0_l3", wr_data[0][3], 45);

    // Reset in the middle of RUN.
    @(negedge clock);
    set_cfg(3, 1, 0, 0, 0, 8);
    i2c_ifm_start = 1'b1;
    @(negedge clock);
    i2c_ifm_start = 1'b0;
    repeat (10) @(negedge clock);
    chk("t5_busy", i2c_ready, 0);
    rst = 1'b1;
    #1;
    chk("t5_ready", i2c_ready, 1);
    chk("t5_rd_en", ifm_rd_en, 0);
    chk("t5_rd_addr", ifm_rd_addr, 0);
    chk("t5_wr_en", ifm_wr_en, 0);
    chk("t5_pix", pixels_out, 0);
    @(negedge clock);
    rst = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (ifm_wr_en || !i2c_ready) bad++;
    end
    chk("t5_quiet", bad, 0);
    run_op(3, 1, 0, 0, 0, 8, 1'b0);
    chk("t5_wr_cnt", wr_cnt, 72);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_order", ord_err, 0);
    chk("t5_k8_l7", wr_data[8][7], 81);

    // valid_num = 0: straight to done.
    run_op(3, 1, 0, 0, 0, 0, 1'b0);
    chk("t6_wr_cnt", wr_cnt, 0);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_done_cyc", done_cyc, 2);

    // Start without a valid base address.
    @(negedge clock);
    set_cfg(3, 1, 0, 0, 0, 8);
    addr_valid = 1'b0;
    i2c_ifm_start = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (!i2c_ready || ifm_rd_en || ifm_wr_en) bad++;
    end
    i2c_ifm_start = 1'b0;
    addr_valid = 1'b1;
    chk("t7_ignored", bad, 0);

    // Start held high through the whole operation.
    run_op(3, 1, 0, 0, 0, 8, 1'b1);
    chk("t8_done_cnt", done_cnt, 1);
    chk("t8_wr_cnt", wr_cnt, 72);
    chk("t8_k4_l0", wr_data[4][0], 45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
